// File: rtl/shared_bus_arbiter.sv
// Round-robin owner selection for a shared multi-driver bus, with turnaround gaps and a hold limit.
// Optional BUS_KEEPER_EN: bus_data keeps the last driven value outside ownership instead of reading zero.
module shared_bus_arbiter #(
    parameter int N        = 4,
    parameter int W        = 8,
    parameter int TURN     = 1,
    parameter int MAX_HOLD = 16,
    localparam int IDW     = (N > 1) ? $clog2(N) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N-1:0]     req,
    input  logic [N*W-1:0]   din,
    output logic [N-1:0]     grant,
    output logic [N-1:0]     bus_oe,
    output logic [W-1:0]     bus_data,
    output logic [IDW-1:0]   owner_id,
    output logic             bus_busy
);
    localparam int HCW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
    localparam int TCW = (TURN > 1) ? $clog2(TURN) : 1;
    localparam logic [HCW-1:0] HOLD_LAST = HCW'(MAX_HOLD - 1);
    localparam logic [TCW-1:0] TURN_LAST = TCW'(TURN - 1);

    typedef enum logic [1:0] {ST_IDLE, ST_OWN, ST_TURN} state_t;

    state_t         state_reg, state_next;
    logic [N-1:0]   grant_reg, grant_next;
    logic [IDW-1:0] owner_reg, owner_next;
    logic [IDW-1:0] ptr_reg, ptr_next;
    logic [HCW-1:0] hold_reg, hold_next;
    logic [TCW-1:0] turn_reg, turn_next;

    logic [W-1:0]   din_slice [N];
    logic [IDW-1:0] sel;
    logic           sel_valid;
    logic           other_req;

    for (genvar gi = 0; gi < N; gi++) begin : g_slice
        assign din_slice[gi] = din[gi*W +: W];
    end

    // Walk downward from the farthest candidate so the nearest one after the pointer wins.
    always_comb begin
        int idx;
        sel       = '0;
        sel_valid = 1'b0;
        idx       = 0;
        for (int k = N; k >= 1; k--) begin
            idx = (int'(ptr_reg) + k) % N;
            if (req[idx]) begin
                sel       = IDW'(idx);
                sel_valid = 1'b1;
            end
        end
    end

    assign other_req = |(req & ~grant_reg);

    always_comb begin
        state_next = state_reg;
        grant_next = grant_reg;
        owner_next = owner_reg;
        ptr_next   = ptr_reg;
        hold_next  = hold_reg;
        turn_next  = turn_reg;
        case (state_reg)
            ST_IDLE: begin
                if (sel_valid) begin
                    state_next = ST_OWN;
                    grant_next = N'(1) << sel;
                    owner_next = sel;
                    ptr_next   = sel;
                    hold_next  = '0;
                end
            end
            ST_OWN: begin
                if (!req[owner_reg] || (hold_reg == HOLD_LAST && other_req)) begin
                    state_next = ST_TURN;
                    grant_next = '0;
                    turn_next  = '0;
                end else if (hold_reg != HOLD_LAST) begin
                    hold_next = hold_reg + HCW'(1);
                end
            end
            ST_TURN: begin
                if (turn_reg == TURN_LAST) begin
                    state_next = ST_IDLE;
                end else begin
                    turn_next = turn_reg + TCW'(1);
                end
            end
            default: begin
                state_next = ST_IDLE;
                grant_next = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_IDLE;
            grant_reg <= '0;
            owner_reg <= '0;
            ptr_reg   <= IDW'(N - 1);
            hold_reg  <= '0;
            turn_reg  <= '0;
        end else begin
            state_reg <= state_next;
            grant_reg <= grant_next;
            owner_reg <= owner_next;
            ptr_reg   <= ptr_next;
            hold_reg  <= hold_next;
            turn_reg  <= turn_next;
        end
    end

`ifdef BUS_KEEPER_EN
    logic [W-1:0] keeper_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            keeper_reg <= '0;
        end else if (state_reg == ST_OWN) begin
            keeper_reg <= bus_data;
        end
    end

    assign bus_data = (state_reg == ST_OWN) ? din_slice[owner_reg] : keeper_reg;
`else
    assign bus_data = (state_reg == ST_OWN) ? din_slice[owner_reg] : '0;
`endif

    assign grant    = grant_reg;
    assign bus_oe   = grant_reg;
    assign owner_id = owner_reg;
    assign bus_busy = (state_reg != ST_IDLE);
endmodule

// File: tb/tb_shared_bus_arbiter.sv
// Randomized scoreboard bench for shared_bus_arbiter against a cycle-level ownership model.
// Define BUS_KEEPER_EN for both bench and design to check the keeper variant.
module tb_shared_bus_arbiter;
    localparam int N        = 4;
    localparam int W        = 8;
    localparam int TURN     = 1;
    localparam int MAX_HOLD = 16;
    localparam int IDW      = $clog2(N);

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [N-1:0]     req = '0;
    logic [N*W-1:0]   din = '0;
    logic [N-1:0]     grant;
    logic [N-1:0]     bus_oe;
    logic [W-1:0]     bus_data;
    logic [IDW-1:0]   owner_id;
    logic             bus_busy;

    shared_bus_arbiter #(.N(N), .W(W), .TURN(TURN), .MAX_HOLD(MAX_HOLD)) dut (
        .clk(clk), .rst(rst), .req(req), .din(din),
        .grant(grant), .bus_oe(bus_oe), .bus_data(bus_data),
        .owner_id(owner_id), .bus_busy(bus_busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [N-1:0] grant;
        logic [W-1:0] data;
        logic [IDW-1:0] id;
        logic busy;
    } exp_t;

    exp_t exp_q[$];
    int errors = 0;
    int checks = 0;
    int cycle  = 0;

    // Model: who owns the bus, for how many cycles, and how much turnaround is left.
    int           m_owner;
    int           m_held;
    int           m_gap;
    int           m_last_id;
    int           m_prev;
    logic [W-1:0] m_kept;

    function automatic logic [W-1:0] slice_of(input logic [N*W-1:0] d, input int i);
        return d[i*W +: W];
    endfunction

    task automatic model_step(input logic r, input logic [N-1:0] rq, input logic [N*W-1:0] d);
        exp_t e;
        if (r) begin
            m_owner = -1; m_held = 0; m_gap = 0; m_last_id = 0; m_prev = N - 1; m_kept = '0;
        end else if (m_owner >= 0) begin
            m_kept = slice_of(d, m_owner);
            if (!rq[m_owner] || (m_held >= MAX_HOLD - 1 && (rq & ~(N'(1) << m_owner)) != 0)) begin
                m_owner = -1;
                m_gap   = TURN;
            end else begin
                m_held++;
            end
        end else if (m_gap > 0) begin
            m_gap--;
        end else begin
            for (int k = 1; k <= N; k++) begin
                int i;
                i = (m_prev + k) % N;
                if (rq[i]) begin
                    m_owner = i; m_prev = i; m_last_id = i; m_held = 0;
                    break;
                end
            end
        end
        e.grant = (m_owner >= 0) ? (N'(1) << m_owner) : '0;
        e.busy  = (m_owner >= 0) || (m_gap > 0);
        e.id    = IDW'(m_last_id);
`ifdef BUS_KEEPER_EN
        e.data  = (m_owner >= 0) ? slice_of(d, m_owner) : m_kept;
`else
        e.data  = (m_owner >= 0) ? slice_of(d, m_owner) : '0;
`endif
        exp_q.push_back(e);
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL cyc=%0d %s got=%0h want=%0h", cycle, name, got, want);
        end
    endtask

    // Monitor: one expected record per clock edge, compared just after the edge.
    initial begin
        logic [N-1:0] prev_oe;
        exp_t e;
        prev_oe = '0;
        forever begin
            @(posedge clk);
            #1;
            cycle++;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("grant", 32'(grant), 32'(e.grant));
                check("bus_oe", 32'(bus_oe), 32'(e.grant));
                check("bus_data", 32'(bus_data), 32'(e.data));
                check("owner_id", 32'(owner_id), 32'(e.id));
                check("bus_busy", 32'(bus_busy), 32'(e.busy));
                check("onehot", 32'($countones(bus_oe) <= 1), 32'(1));
                check("no_direct_handover",
                      32'(prev_oe != 0 && bus_oe != 0 && bus_oe != prev_oe), 32'(0));
                $display("cyc=%0d rst=%0b req=%b grant=%b id=%0d data=%h busy=%0b",
                         cycle, rst, req, grant, owner_id, bus_data, bus_busy);
                prev_oe = bus_oe;
            end
        end
    end

    initial begin
        logic [N-1:0] r;
        logic [N-1:0] flip;
        int mode;
        r = '0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            rst = 1'b1; req = '0;
            model_step(rst, req, din);
        end
        for (int seg = 0; seg < 40; seg++) begin
            mode = seg % 4;
            for (int c = 0; c < 75; c++) begin
                @(negedge clk);
                case (mode)
                    0: r = N'($urandom);
                    1: begin
                        flip = '0;
                        for (int b = 0; b < N; b++) flip[b] = ($urandom_range(0, 7) == 0);
                        r = r ^ flip;
                    end
                    2: r = '1;
                    default: r = ($urandom_range(0, 3) == 0) ? '0 : (N'(1) << $urandom_range(0, N - 1));
                endcase
                for (int i = 0; i < N; i++) din[i*W +: W] = W'($urandom);
                rst = ($urandom_range(0, 199) == 0);
                req = r;
                model_step(rst, req, din);
            end
        end
        @(negedge clk);
        rst = 1'b0; req = '0;
        @(posedge clk);
        #2;
        check("queue_drained", 32'(exp_q.size()), 32'(0));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
